seq_det_ctrl: RTL and testbench

Byte-stream controller for a programmable 4-bit serial pattern matcher. It accepts bytes over a valid/ready handshake and serializes each one MSB-first into a shared matcher core, one bit per cycle. It counts detections in a saturating counter and raises a sticky interrupt when the count reaches a programmed threshold. It sits between a byte-wide source and the serial detection logic of the pattern-detector family (0101-style detectors), replacing hard-wired single-pattern FSMs.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_match_core.sv | 60 ++++++
 rtl/seq_det_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family.
// Holds the controller state encoding, default widths and the byte width.
package seq_det_pkg;

    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher core: PAT_W-bit history plus fill count, with a
// combinational match flag for the bit currently being shifted in.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   bit_in    - serial bit presented this cycle
//   bit_vld   - bit_in is valid and is shifted in at the next edge
//   pattern   - pattern to match, first-received bit in the MSB
//   overlap   - 1 keeps history after a match, 0 restarts the fill count
//   clr       - synchronous clear of history and fill; suppresses match
//   match     - combinational: this bit completes the pattern
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr,
    output logic             match
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

    // Compare happens on the history as it will look after this bit.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], bit_in};
        fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
        match      = bit_vld && !clr &&
                     (fill_inc == FILL_W'(PAT_W)) && (hist_shift == pattern);

        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_vld) begin
            hist_d = hist_shift;
            // Non-overlap: the matched bits cannot start the next match.
            fill_d = (match && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Byte-stream controller for the serial pattern matcher. Accepts bytes on a
// valid/ready handshake, shifts them MSB-first into seq_match_core one bit
// per cycle, counts detections (saturating) and raises a sticky irq when
// the count reaches the programmed threshold.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   cfg_pattern  - pattern (first-received bit is MSB), sampled per byte
//   cfg_overlap  - overlapping detection enable, sampled per byte
//   cfg_thresh   - irq threshold, 0 disables
//   clr          - sync clear of counter, irq, history; aborts current byte
//   in_valid/in_data/in_ready - byte input handshake
//   det          - one-cycle detection pulse
//   match_cnt    - saturating detection count
//   irq          - sticky threshold-reached flag
//   busy         - a byte is being shifted
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              det,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              det_q, det_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              irq_q, irq_d;

    logic              accept;
    logic              core_bit;
    logic              core_vld;
    logic              core_match;

    assign core_bit = byte_q[idx_q];
    assign core_vld = (state_q == ST_SHIFT);

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .bit_in  (core_bit),
        .bit_vld (core_vld),
        .pattern (pat_q),
        .overlap (ovl_q),
        .clr     (clr),
        .match   (core_match)
    );

    // Next-state, byte latch and registered handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        pat_d      = pat_q;
        ovl_d      = ovl_q;
        accept     = in_valid && in_ready_q && !clr;

        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (idx_q == '0) begin
                        // Last bit: chain straight into the next byte if offered.
                        if (!accept) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Configuration is captured only together with a new byte.
        if (accept) begin
            byte_d = in_data;
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            idx_d  = IDX_W'(BYTE_W - 1);
        end

        in_ready_d = (state_d == ST_IDLE) || (idx_d == '0);
        busy_d     = (state_d == ST_SHIFT);
    end

    // Detection pulse, saturating counter and sticky irq.
    always_comb begin
        det_d = core_match;
        cnt_d = cnt_q;
        irq_d = irq_q;
        if (clr) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else begin
            if (core_match && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Compare against the post-update count so irq rises with det;
            // >= also catches a threshold lowered below the current count.
            if ((cfg_thresh != '0) && (cnt_d >= cfg_thresh)) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            byte_q     <= '0;
            pat_q      <= '0;
            ovl_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            det_q      <= 1'b0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            pat_q      <= pat_d;
            ovl_q      <= ovl_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            det_q      <= det_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign det       = det_q;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl (CNT_W=4 so saturation is reachable).
// Each byte is observed over a 20-sample window starting at its acceptance
// edge; per-sample det/busy/in_ready/irq bits are compared against
// hand-derived masks (bit k = sample taken just after edge k).
module tb_seq_det_ctrl;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [3:0]    cfg_pattern;
    logic          cfg_overlap;
    logic [CW-1:0] cfg_thresh;
    logic          clr;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          det;
    logic [CW-1:0] match_cnt;
    logic          irq;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [19:0] det_v, busy_v, rdy_v, irq_v;

    seq_det_ctrl #(
        .PAT_W (4),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_thresh  (cfg_thresh),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .det         (det),
        .match_cnt   (match_cnt),
        .irq         (irq),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer b0 (and b1 back-to-back when two=1) and record 20 samples.
    task automatic watch(input logic two, input logic [7:0] b0, input logic [7:0] b1);
        in_valid = 1'b1;
        in_data  = b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            det_v[k]  = det;
            busy_v[k] = busy;
            rdy_v[k]  = in_ready;
            irq_v[k]  = irq;
            if (k == 0) begin
                if (two) in_data = b1;
                else     in_valid = 1'b0;
            end
            if (k == 8) in_valid = 1'b0;
            if (k < 19) tick();
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        cfg_pattern = 4'b0101;
        cfg_overlap = 1'b1;
        cfg_thresh  = '0;
        clr         = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_det", 32'(det), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b1;

        // 0x55, overlap: matches complete at bits 3,5,7 of the stream.
        watch(1'b0, 8'h55, 8'h00);
        chk("ovl55_det", 32'(det_v), 32'h00150);
        chk("ovl55_busy", 32'(busy_v), 32'h000FF);
        chk("ovl55_rdy", 32'(rdy_v), 32'hFFF80);
        chk("ovl55_cnt", 32'(match_cnt), 32'd3);

        // clr with in_valid: byte refused, counter cleared.
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_vld_busy", 32'(busy), 32'd0);
        chk("clr_vld_cnt", 32'(match_cnt), 32'd0);
        chk("clr_vld_rdy", 32'(in_ready), 32'd1);

        // 0x55, non-overlap: matches at bits 3 and 7 only.
        cfg_overlap = 1'b0;
        watch(1'b0, 8'h55, 8'h00);
        chk("novl55_det", 32'(det_v), 32'h00110);
        chk("novl55_cnt", 32'(match_cnt), 32'd2);

        // Back-to-back 0x05,0x50 overlap: stream 0000_0101_0101_0000 has
        // 0101 ending at stream bits 7, 9 and 11.
        pulse_clr();
        cfg_overlap = 1'b1;
        watch(1'b1, 8'h05, 8'h50);
        chk("b2b_det", 32'(det_v), 32'h01500);
        chk("b2b_busy", 32'(busy_v), 32'h0FFFF);
        chk("b2b_rdy", 32'(rdy_v), 32'hF8080);
        chk("b2b_cnt", 32'(match_cnt), 32'd3);

        // Threshold 2: irq rises with the second det and holds.
        pulse_clr();
        cfg_thresh = 4'd2;
        watch(1'b0, 8'h55, 8'h00);
        chk("thr_det", 32'(det_v), 32'h00150);
        chk("thr_irq", 32'(irq_v), 32'hFFFC0);
        chk("thr_cnt", 32'(match_cnt), 32'd3);
        pulse_clr();
        chk("thr_clr_cnt", 32'(match_cnt), 32'd0);
        chk("thr_clr_irq", 32'(irq), 32'd0);

        // Threshold lowered below an existing count.
        cfg_thresh = 4'd5;
        watch(1'b0, 8'h55, 8'h00);
        chk("low_pre_irq", 32'(irq), 32'd0);
        chk("low_pre_cnt", 32'(match_cnt), 32'd3);
        cfg_thresh = 4'd2;
        tick();
        chk("low_post_irq", 32'(irq), 32'd1);

        // Saturation: 3 + 4 + 4 + 4 = 15 after four 0x55 bytes.
        pulse_clr();
        cfg_thresh = '0;
        watch(1'b0, 8'h55, 8'h00);
        watch(1'b0, 8'h55, 8'h00);
        chk("sat_cnt7", 32'(match_cnt), 32'd7);
        watch(1'b0, 8'h55, 8'h00);
        watch(1'b0, 8'h55, 8'h00);
        chk("sat_cnt15", 32'(match_cnt), 32'd15);
        watch(1'b0, 8'h55, 8'h00);
        chk("sat_det", 32'(det_v), 32'h00154);
        chk("sat_hold", 32'(match_cnt), 32'd15);

        // Async reset at index 4 of a byte.
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        chk("arst_cnt", 32'(match_cnt), 32'd0);
        chk("arst_det", 32'(det), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        #2;
        rst = 1'b1;

        // 0x0A: 0101 sits at stream bits 3..6, det one sample after bit 6.
        watch(1'b0, 8'h0A, 8'h00);
        chk("post_rst_det", 32'(det_v), 32'h00080);
        chk("post_rst_cnt", 32'(match_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
